// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and LCD address helper for the frame scheduler.
package lcd_pkg;

   localparam int FRAME_BYTES = 1024;
   localparam int PAGE_COLS   = 128;
   localparam int PAGES       = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HOLD,
      ST_NEXT
   } sched_state_e;

   // LCD12864 byte address: 8 pages of 128 columns, page-major.
   function automatic logic [9:0] lcd_addr(input logic [2:0] page, input logic [6:0] col);
      return 10'(page) * 10'(PAGE_COLS) + 10'(col);
   endfunction

endpackage

// File: rtl/lcd_ms_timer.sv
// Millisecond hold timer: a T1MS cycle prescaler feeding a ms counter; done flags the final cycle.
module lcd_ms_timer #(
   parameter int T1MS = 49999
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear_i,
   input  logic       enable_i,
   input  logic [9:0] target_ms_i,
   output logic       done_o
);

   localparam int CW = (T1MS > 0) ? $clog2(T1MS + 1) : 1;

   logic [CW-1:0] cyc_q, cyc_d;
   logic [9:0]    ms_q, ms_d;
   logic          tick;

   assign tick = enable_i && (cyc_q == CW'(T1MS));

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cyc_d = cyc_q;
      ms_d  = ms_q;
      if (clear_i) begin
         cyc_d = '0;
         ms_d  = '0;
      end else if (enable_i) begin
         if (tick) begin
            cyc_d = '0;
            ms_d  = ms_q + 10'd1;
         end else begin
            cyc_d = cyc_q + CW'(1);
         end
      end
   end

   // NOTE: non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q <= '0;
         ms_q  <= '0;
      end else begin
         cyc_q <= cyc_d;
         ms_q  <= ms_d;
      end
   end

   // High in the last cycle of the hold so the FSM leaves after exactly target_ms milliseconds.
   assign done_o = tick && (ms_q == target_ms_i - 10'd1);

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Slideshow frame uploader from frame ROM to the LCD write port, with optional host byte port.
// Define LCD_SCHED_HOST_EN to compile in the host port and arbiter.
module lcd_frame_scheduler
   import lcd_pkg::*;
#(
   parameter  int T1MS       = 49999,
   parameter  int HOLD_MS    = 500,
   parameter  int NUM_FRAMES = 2,
   localparam int FW         = $clog2(NUM_FRAMES)
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic            Start_Sig,
   output logic [10+FW-1:0] Rom_Addr,
   input  logic [7:0]      Rom_Data,
   input  logic            Host_Req,
   input  logic [9:0]      Host_Addr,
   input  logic [7:0]      Host_Data,
   output logic            Host_Ack,
   output logic            Write_En_Sig,
   output logic [9:0]      Write_Addr_Sig,
   output logic [7:0]      Write_Data,
   output logic [FW-1:0]   Frame_Idx,
   output logic            Busy_Sig,
   output logic            Frame_Done_Sig
);

   sched_state_e  state_q, state_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [9:0]    byte_q, byte_d;
   logic          done_q, done_d;
   logic          wr_en_q, wr_host_q;
   logic [9:0]    wr_addr_q;
   logic [7:0]    host_data_q;
   logic          host_grant, stream_slot, hold_done;

`ifdef LCD_SCHED_HOST_EN
   logic host_last_q;

   // Host takes every free slot, but yields to the stream right after a host win during LOAD.
   assign host_grant = RSTn && Host_Req && !((state_q == ST_LOAD) && host_last_q);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) host_last_q <= 1'b0;
      else       host_last_q <= host_grant;
   end
`else
   logic unused_host_req;

   assign unused_host_req = Host_Req;
   assign host_grant      = 1'b0;
`endif

   assign stream_slot = (state_q == ST_LOAD) && !host_grant;

   lcd_ms_timer #(
      .T1MS (T1MS)
   ) u_ms_timer (
      .clk         (CLK),
      .rst_n       (RSTn),
      .clear_i     (state_q != ST_HOLD),
      .enable_i    (state_q == ST_HOLD),
      .target_ms_i (10'(HOLD_MS)),
      .done_o      (hold_done)
   );

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      byte_d  = byte_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Start_Sig) begin
               state_d = ST_LOAD;
               byte_d  = '0;
            end
         end
         ST_LOAD: begin
            // Start_Sig is ignored here: a started frame always completes.
            if (stream_slot) begin
               if (byte_q == 10'(FRAME_BYTES - 1)) begin
                  state_d = ST_HOLD;
                  done_d  = 1'b1;
               end else begin
                  byte_d = byte_q + 10'd1;
               end
            end
         end
         ST_HOLD: begin
            if (hold_done) state_d = Start_Sig ? ST_NEXT : ST_IDLE;
         end
         ST_NEXT: begin
            frame_d = frame_q + FW'(1);
            byte_d  = '0;
            state_d = ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= ST_IDLE;
         frame_q     <= '0;
         byte_q      <= '0;
         done_q      <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_host_q   <= 1'b0;
         wr_addr_q   <= '0;
         host_data_q <= '0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         byte_q    <= byte_d;
         done_q    <= done_d;
         wr_en_q   <= host_grant || stream_slot;
         wr_host_q <= host_grant;
         if (host_grant) begin
            wr_addr_q   <= Host_Addr;
            host_data_q <= Host_Data;
         end else if (stream_slot) begin
            wr_addr_q <= lcd_addr(byte_q[9:7], byte_q[6:0]);
         end
      end
   end

   // The ROM output register is the data half of the write stage, so stream data passes straight through.
   assign Write_Data     = !wr_en_q ? 8'h00 : (wr_host_q ? host_data_q : Rom_Data);
   assign Write_En_Sig   = wr_en_q;
   assign Write_Addr_Sig = wr_addr_q;
   assign Rom_Addr       = {frame_q, byte_q};
   assign Frame_Idx      = frame_q;
   assign Busy_Sig       = (state_q != ST_IDLE);
   assign Frame_Done_Sig = done_q;
   assign Host_Ack       = host_grant;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed bench for lcd_frame_scheduler: startup table, frame streaming, hold, wrap, host and reset cases.
module tb_lcd_frame_scheduler;

   localparam int T1MS       = 9;
   localparam int HOLD_MS    = 3;
   localparam int NUM_FRAMES = 2;
   localparam int HOLD_CYC   = HOLD_MS * (T1MS + 1);

   logic        clk = 1'b0;
   logic        RSTn;
   logic        Start_Sig;
   logic [10:0] Rom_Addr;
   logic [7:0]  Rom_Data = 8'h00;
   logic        Host_Req;
   logic [9:0]  Host_Addr;
   logic [7:0]  Host_Data;
   logic        Host_Ack;
   logic        Write_En_Sig;
   logic [9:0]  Write_Addr_Sig;
   logic [7:0]  Write_Data;
   logic [0:0]  Frame_Idx;
   logic        Busy_Sig;
   logic        Frame_Done_Sig;

   int checks   = 0;
   int failures = 0;

   lcd_frame_scheduler #(
      .T1MS       (T1MS),
      .HOLD_MS    (HOLD_MS),
      .NUM_FRAMES (NUM_FRAMES)
   ) dut (
      .CLK            (clk),
      .RSTn           (RSTn),
      .Start_Sig      (Start_Sig),
      .Rom_Addr       (Rom_Addr),
      .Rom_Data       (Rom_Data),
      .Host_Req       (Host_Req),
      .Host_Addr      (Host_Addr),
      .Host_Data      (Host_Data),
      .Host_Ack       (Host_Ack),
      .Write_En_Sig   (Write_En_Sig),
      .Write_Addr_Sig (Write_Addr_Sig),
      .Write_Data     (Write_Data),
      .Frame_Idx      (Frame_Idx),
      .Busy_Sig       (Busy_Sig),
      .Frame_Done_Sig (Frame_Done_Sig)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_f(input logic [10:0] a);
      return a[7:0] ^ {5'b0, a[10:8]};
   endfunction

   // Synchronous frame ROM model.
   always @(posedge clk) Rom_Data <= rom_f(Rom_Addr);

   function automatic logic [63:0] outs();
      return {30'd0, Rom_Addr, Write_En_Sig, Write_Addr_Sig, Write_Data,
              Host_Ack, Busy_Sig, Frame_Done_Sig, Frame_Idx};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Advance one cycle, apply inputs for it, and return at the falling edge for sampling.
   task automatic cyc(input logic s, input logic r, input logic [9:0] a, input logic [7:0] d);
      @(posedge clk);
      #1;
      Start_Sig = s;
      Host_Req  = r;
      Host_Addr = a;
      Host_Data = d;
      @(negedge clk);
   endtask

   task automatic wait_write(input logic s, input logic r, input int max_cyc,
                             output int waited, output logic [10:0] prev_rom);
      waited   = max_cyc + 1;
      prev_rom = Rom_Addr;
      for (int i = 1; i <= max_cyc; i++) begin
         cyc(s, r, 10'd5, 8'hA5);
         if (Write_En_Sig === 1'b1) begin
            waited = i;
            break;
         end
         prev_rom = Rom_Addr;
      end
   endtask

   // Checks contiguous stream writes first..last of a frame; Start_Sig drops from byte drop_at on.
   task automatic check_frame(input string name, input int frame, input int first, input int last,
                              input bit skip, input int drop_at, input logic req);
      int          errs;
      int          exp_rom;
      logic [10:0] ea;
      errs = 0;
      for (int idx = first; idx <= last; idx++) begin
         if (!(skip && idx == first)) cyc(idx < drop_at, req, 10'd5, 8'hA5);
         ea      = {1'(frame), idx[9:0]};
         exp_rom = (idx < 1023) ? idx + 1 : 1023;
         if (Write_En_Sig !== 1'b1 || Write_Addr_Sig !== idx[9:0] || Write_Data !== rom_f(ea)
             || Frame_Done_Sig !== (idx == 1023) || Frame_Idx !== 1'(frame) || Host_Ack !== 1'b0
             || Rom_Addr !== {1'(frame), exp_rom[9:0]} || Busy_Sig !== 1'b1)
            errs++;
      end
      check(name, 64'(errs), 64'd0);
   endtask

   typedef struct {
      logic        start;
      logic [10:0] rom;
      logic        we;
      logic [9:0]  waddr;
      logic [7:0]  wdata;
      logic        busy;
   } vec_t;

   vec_t        vecs[5];
   int          waited;
   int          busy_cnt;
   int          errs;
   int          acks;
   int          j;
   logic [10:0] prev_rom;
   logic [9:0]  exp_wa;
   logic [7:0]  exp_wd;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          start rom    we  waddr  wdata  busy
      vecs[0] = '{1'b0, 11'd0, 1'b0, 10'd0, 8'd0, 1'b0};
      vecs[1] = '{1'b1, 11'd0, 1'b0, 10'd0, 8'd0, 1'b0};
      vecs[2] = '{1'b1, 11'd0, 1'b0, 10'd0, 8'd0, 1'b1};
      vecs[3] = '{1'b1, 11'd1, 1'b1, 10'd0, 8'd0, 1'b1};
      vecs[4] = '{1'b1, 11'd2, 1'b1, 10'd1, 8'd1, 1'b1};

      RSTn      = 1'b0;
      Start_Sig = 1'b1;
      Host_Req  = 1'b1;
      Host_Addr = 10'd5;
      Host_Data = 8'hA5;
      repeat (2) @(negedge clk);
      check("reset_outputs", outs(), 64'd0);
      Start_Sig = 1'b0;
      Host_Req  = 1'b0;
      @(negedge clk);
      RSTn = 1'b1;

      for (int i = 0; i < 5; i++) begin
         cyc(vecs[i].start, 1'b0, 10'd0, 8'd0);
         check($sformatf("startup_vec%0d", i), outs(),
               {30'd0, vecs[i].rom, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                1'b0, vecs[i].busy, 1'b0, 1'b0});
      end

      // Frame 0, hold, frame 1, hold, wrap back to frame 0.
      check_frame("frame0_stream", 0, 2, 1023, 1'b0, 2000, 1'b0);
      wait_write(1'b1, 1'b0, 100, waited, prev_rom);
      check("hold_gap_0to1", 64'(waited), 64'(HOLD_CYC + 2));
      check("frame1_first_rom_addr", 64'(prev_rom), 64'd1024);
      check_frame("frame1_stream", 1, 0, 1023, 1'b1, 2000, 1'b0);
      wait_write(1'b1, 1'b0, 100, waited, prev_rom);
      check("hold_gap_1to0", 64'(waited), 64'(HOLD_CYC + 2));
      check("wrap_first_rom_addr", 64'(prev_rom), 64'd0);

      // Start_Sig drops at byte 300: frame completes, hold runs, then idle.
      check_frame("wrap_frame_start_drop", 0, 0, 1023, 1'b1, 300, 1'b0);
      busy_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1'b0, 1'b0, 10'd0, 8'd0);
         if (Busy_Sig !== 1'b1) break;
         busy_cnt++;
      end
      check("hold_then_idle_busy_cycles", 64'(busy_cnt), 64'(HOLD_CYC - 1));
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         if (Busy_Sig !== 1'b0 || Write_En_Sig !== 1'b0 || Frame_Idx !== 1'b0) errs++;
         cyc(1'b0, 1'b0, 10'd0, 8'd0);
      end
      check("idle_after_stop", 64'(errs), 64'd0);

`ifdef LCD_SCHED_HOST_EN
      // Host write in IDLE: ack in the request cycle, write the next cycle.
      cyc(1'b0, 1'b1, 10'd5, 8'hA5);
      check("idle_host_ack", {62'd0, Host_Ack, Write_En_Sig}, {62'd0, 1'b1, 1'b0});
      cyc(1'b0, 1'b0, 10'd0, 8'd0);
      check("idle_host_write", {35'd0, Write_En_Sig, Write_Addr_Sig, Write_Data, Host_Ack, Busy_Sig},
            {35'd0, 1'b1, 10'd5, 8'hA5, 1'b0, 1'b0});

      // Host requesting throughout LOAD: slots alternate host/stream, 2048-cycle frame.
      cyc(1'b1, 1'b0, 10'd7, 8'h3C);
      check("contended_start_no_ack", {63'd0, Host_Ack}, 64'd0);
      acks = 0;
      errs = 0;
      for (int k = 0; k <= 2048; k++) begin
         cyc(1'b1, k < 2048, 10'd7, 8'h3C);
         if (Host_Ack === 1'b1) acks++;
         if (Host_Ack !== (k < 2048 && k % 2 == 0)) errs++;
         if (k >= 1) begin
            if ((k - 1) % 2 == 0) begin
               exp_wa = 10'd7;
               exp_wd = 8'h3C;
            end else begin
               j      = (k - 2) / 2;
               exp_wa = j[9:0];
               exp_wd = rom_f({1'b0, j[9:0]});
            end
            if (Write_En_Sig !== 1'b1 || Write_Addr_Sig !== exp_wa || Write_Data !== exp_wd) errs++;
         end else if (Write_En_Sig !== 1'b0) begin
            errs++;
         end
         if (Frame_Done_Sig !== (k == 2048)) errs++;
      end
      check("contended_ack_count", 64'(acks), 64'd1024);
      check("contended_alternation", 64'(errs), 64'd0);
`else
      // Host port compiled out: requests are never acked and never disturb the stream.
      wait_write(1'b1, 1'b1, 10, waited, prev_rom);
      check("start_to_first_write", 64'(waited), 64'd3);
      check_frame("host_ignored_frame", 0, 0, 1023, 1'b1, 2000, 1'b1);
`endif

      // Reset in the middle of frame 1 at byte 500.
      wait_write(1'b1, 1'b0, 100, waited, prev_rom);
      check("hold_gap_before_reset_frame", 64'(waited), 64'(HOLD_CYC + 2));
      check_frame("frame1_before_reset", 1, 0, 500, 1'b1, 2000, 1'b0);
      #2;
      RSTn      = 1'b0;
      Start_Sig = 1'b0;
      #1;
      check("async_reset_outputs", outs(), 64'd0);
      repeat (3) @(negedge clk);
      RSTn = 1'b1;
      wait_write(1'b1, 1'b0, 10, waited, prev_rom);
      check("restart_latency", 64'(waited), 64'd3);
      check_frame("restart_frame0", 0, 0, 20, 1'b1, 2000, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
